// File: rtl/adder_share_sched.sv
// One registered adder shared by NREQ requesters through a round-robin grant,
// feeding an ADD_LAT-stage pipeline that returns tagged sums with backpressure.
module adder_share_sched #(
   parameter int WIDTH   = 10,
   parameter int NREQ    = 4,
   parameter int ADD_LAT = 2,
   parameter int IDW     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_carry,
   output logic [15:0]           stall_cnt
);

   // Pipeline stages; r_sum carries the carry-out in its top bit.
   logic             r_valid [ADD_LAT];
   logic [IDW-1:0]   r_id    [ADD_LAT];
   logic [WIDTH:0]   r_sum   [ADD_LAT];
   logic [IDW-1:0]   r_ptr;
   logic [15:0]      r_stall_cnt;

   logic             w_stall;
   logic             w_found;
   logic             w_grant;
   logic [IDW-1:0]   w_scan;
   logic [IDW-1:0]   w_gnt_idx;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH:0]   w_sum;

   assign w_stall = r_valid[ADD_LAT-1] & ~rsp_ready;

   // NOTE: combinational blocks use blocking '=' and assign every output a
   // default first, so no path leaves a signal unassigned and no latch appears.
   always_comb begin
      w_found   = 1'b0;
      w_scan    = '0;
      w_gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_scan = IDW'((32'(r_ptr) + 32'(k)) % NREQ);
         if (!w_found && req_valid[w_scan]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_scan;
         end
      end
   end

   assign w_grant = w_found & ~w_stall & ~rst;

   always_comb begin
      req_ready = '0;
      if (w_grant) req_ready[w_gnt_idx] = 1'b1;
   end

   assign w_a   = req_a[w_gnt_idx*WIDTH +: WIDTH];
   assign w_b   = req_b[w_gnt_idx*WIDTH +: WIDTH];
   assign w_sum = {1'b0, w_a} + {1'b0, w_b};

   // NOTE: sequential state uses non-blocking '<=' only. Data registers are
   // reset alongside the valid bits so the response fields never show X.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ADD_LAT; k++) begin
            r_valid[k] <= 1'b0;
            r_id[k]    <= '0;
            r_sum[k]   <= '0;
         end
         r_ptr       <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_stall && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if (!w_stall) begin
            r_valid[0] <= w_grant;
            if (w_grant) begin
               r_id[0]  <= w_gnt_idx;
               r_sum[0] <= w_sum;
               r_ptr    <= IDW'((32'(w_gnt_idx) + 32'd1) % NREQ);
            end
            // Payload only moves with a valid entry, so bubbles leave the last value in place.
            for (int k = 1; k < ADD_LAT; k++) begin
               r_valid[k] <= r_valid[k-1];
               if (r_valid[k-1]) begin
                  r_id[k]  <= r_id[k-1];
                  r_sum[k] <= r_sum[k-1];
               end
            end
         end
      end
   end

   assign rsp_valid = r_valid[ADD_LAT-1];
   assign rsp_id    = r_id[ADD_LAT-1];
   assign rsp_sum   = r_sum[ADD_LAT-1][WIDTH-1:0];
   assign rsp_carry = r_sum[ADD_LAT-1][WIDTH];
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_adder_share_sched.sv
// Directed bench for adder_share_sched: stimulus pushes hand-computed responses
// into a queue, an independent monitor compares them as the DUT emits results.
module tb_adder_share_sched;

   localparam int WIDTH = 10;
   localparam int NREQ  = 4;

   typedef struct packed {
      logic [1:0]       id;
      logic [WIDTH-1:0] sum;
      logic             carry;
   } rsp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [1:0]            rsp_id;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_carry;
   logic [15:0]           stall_cnt;

   int   n_checks = 0;
   int   n_pass   = 0;
   rsp_t exp_q[$];

   // Operand table and hand-computed results for each requester.
   logic [WIDTH-1:0] op_a    [NREQ];
   logic [WIDTH-1:0] op_b    [NREQ];
   logic [WIDTH-1:0] tab_sum [NREQ];
   logic             tab_c   [NREQ];

   adder_share_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .ADD_LAT(2), .IDW(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      @(negedge clk);
   endtask

   task automatic apply_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*WIDTH +: WIDTH] = op_a[i];
         req_b[i*WIDTH +: WIDTH] = op_b[i];
      end
   endtask

   function automatic logic [NREQ-1:0] onehot(input int id);
      logic [NREQ-1:0] v;
      v = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   task automatic push_tab(input int id);
      rsp_t e;
      e.id    = 2'(id);
      e.sum   = tab_sum[id];
      e.carry = tab_c[id];
      exp_q.push_back(e);
   endtask

   // Monitor: compares every visible response with the queue head, pops on transfer.
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            check("rsp_id",    32'(rsp_id),    32'(exp_q[0].id));
            check("rsp_sum",   32'(rsp_sum),   32'(exp_q[0].sum));
            check("rsp_carry", 32'(rsp_carry), 32'(exp_q[0].carry));
            if (rsp_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int rr_seq [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
      int sk_seq [3] = '{3, 0, 3};
      int bp_seq [6] = '{0, 1, 2, 3, 0, 1};
      int g;
      logic stall_c;

      op_a    = '{10'h001, 10'h3FF, 10'h123, 10'h1FF};
      op_b    = '{10'h002, 10'h001, 10'h0AB, 10'h1FF};
      tab_sum = '{10'h003, 10'h000, 10'h1CE, 10'h3FE};
      tab_c   = '{1'b0,    1'b1,    1'b0,    1'b0};
      apply_ops();

      // Reset: ready stays low even with every requester valid.
      rst = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
      step(); step();
      probe();
      check("reset_ready", 32'(req_ready), 32'h0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset_rsp_sum", 32'(rsp_sum), 32'h0);
      check("reset_rsp_id", 32'(rsp_id), 32'h0);
      check("reset_rsp_carry", 32'(rsp_carry), 32'h0);
      check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
      step();
      rst = 1'b0; req_valid = 4'h0;
      step();

      // Single request from requester 2: 0x123 + 0x0AB = 0x1CE, two-cycle latency.
      req_valid = 4'b0100;
      probe();
      check("single_ready", 32'(req_ready), 32'b0100);
      push_tab(2);
      step();
      req_valid = 4'h0;
      probe();
      check("single_lat1_valid", 32'(rsp_valid), 32'h0);
      step();
      probe();
      check("single_lat2_valid", 32'(rsp_valid), 32'h1);
      step();

      // Round robin with all four valid; pointer sits at 3 after the single grant.
      op_a[2] = 10'h200; op_b[2] = 10'h200;
      tab_sum[2] = 10'h000; tab_c[2] = 1'b1;
      apply_ops();
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         probe();
         check("rr_ready", 32'(req_ready), 32'(onehot(rr_seq[k])));
         if (k >= 2) check("rr_no_gap", 32'(rsp_valid), 32'h1);
         push_tab(rr_seq[k]);
         step();
      end
      req_valid = 4'h0;
      step(); step(); step();

      // Pointer skip: grant 1, then only 0 and 3 valid -> 3, 0, 3.
      req_valid = 4'b0010;
      probe();
      check("skip_ready1", 32'(req_ready), 32'b0010);
      push_tab(1);
      step();
      req_valid = 4'b1001;
      for (int k = 0; k < 3; k++) begin
         probe();
         check("skip_ready", 32'(req_ready), 32'(onehot(sk_seq[k])));
         push_tab(sk_seq[k]);
         step();
      end
      req_valid = 4'h0;
      step(); step(); step();

      // Backpressure: rsp_ready low for four cycles in the middle of a 6-request stream.
      g = 0;
      req_valid = 4'hF;
      for (int c = 0; c < 10; c++) begin
         stall_c   = (c >= 3 && c <= 6);
         rsp_ready = ~stall_c;
         probe();
         if (stall_c) begin
            check("bp_ready_stall", 32'(req_ready), 32'h0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
         end else begin
            check("bp_ready", 32'(req_ready), 32'(onehot(bp_seq[g])));
            push_tab(bp_seq[g]);
            g++;
         end
         step();
      end
      req_valid = 4'h0; rsp_ready = 1'b1;
      step(); step(); step();
      probe();
      check("bp_stall_cnt", 32'(stall_cnt), 32'd4);
      check("bp_drained", 32'(exp_q.size()), 32'd0);
      step();

      // Reset mid-flight: two grants (2 then 3) are discarded.
      req_valid = 4'hF;
      step(); step();
      rst = 1'b1;
      probe();
      check("midrst_ready", 32'(req_ready), 32'h0);
      step();
      rst = 1'b0; req_valid = 4'b1010;
      probe();
      check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("midrst_stall_cnt", 32'(stall_cnt), 32'h0);
      check("midrst_ready_first", 32'(req_ready), 32'b0010);
      push_tab(1);
      step();
      req_valid = 4'h0;
      for (int k = 0; k < 5; k++) step();
      probe();
      check("final_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adder_share_sched.md
Name: adder_share_sched

Overview:
- Shares one registered WIDTH-bit adder among NREQ requesters. Each requester issues (a, b) operand pairs on an independent valid/ready port.
- A round-robin scheduler grants at most one request per cycle and feeds it into an ADD_LAT-stage adder pipeline.
- Each sum returns on a single tagged response port with backpressure.
- Sits between FFT butterfly/twiddle sequencers and the shared adder resource, replacing one adder per consumer.

Parameters:
- WIDTH, 10, operand and sum width in bits.
- NREQ, 4, number of requesters (2..8).
- ADD_LAT, 2, adder pipeline stages from grant to response (1..4).
- IDW, 2, requester-id width; must equal clog2(NREQ).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b, same packing as req_a.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  IDW  index of the requester that issued the operands.
- rsp_sum  out  WIDTH  (a+b) mod 2^WIDTH.
- rsp_carry  out  1  carry out of bit WIDTH-1.
- stall_cnt  out  16  count of cycles with rsp_valid=1 and rsp_ready=0; saturates at 0xFFFF.

Behaviour:
- Reset (rst=1 at a clk edge): all pipeline valid bits, rsp_valid, rsp_id, rsp_sum, rsp_carry and stall_cnt go to 0; round-robin pointer goes to 0; req_ready=0 while rst is high.
- Pipeline: stages S1..S_ADD_LAT, each holding {valid, id, sum, carry}. The sum is computed at S1 entry at full width+1; later stages only delay. rsp_* are the S_ADD_LAT registers.
- Stall: stall = rsp_valid & ~rsp_ready. When stall=1 every stage holds and no grant is issued. There are no bubbles to compress; the pipeline advances as a whole.
- Grant: when stall=0 and rst=0, pick the first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - req_ready[i] is asserted combinationally in the same cycle.
  - The transfer occurs that cycle; S1 captures {1, i, a_i+b_i}.
  - ptr becomes (i+1) mod NREQ. ptr is unchanged if there is no grant.
- req_ready depends on req_valid. A requester must not make its valid depend on ready. Operands must be held stable while valid=1 and ready=0.
- Latency: a grant in cycle t produces rsp_valid in cycle t+ADD_LAT, provided no stall intervenes. Each stall cycle adds 1.
- Throughput: 1 result per cycle when rsp_ready=1 continuously.
- Ordering: responses leave in grant order; per-requester order is preserved.
- Arithmetic: unsigned wrap; rsp_carry = bit WIDTH of the (WIDTH+1)-bit sum. Example for WIDTH=10: 0x3FF + 0x001 gives sum 0x000, carry 1.
- Idle: with no grant, S1.valid=0 and the bubble propagates. rsp_sum/rsp_id are don't-care while rsp_valid=0 but hold their last value (no X).
- Simultaneous stall release and new request: grant in the same cycle rsp_ready rises.
- Reset mid-operation: in-flight results are discarded with no response, and ptr returns to 0.
- stall_cnt increments by 1 per stall cycle and saturates at 0xFFFF; it is cleared only by rst.

Test Plan:
- Single request: NREQ=4, ADD_LAT=2, req 2 with a=0x123, b=0x0AB at cycle 5 -> req_ready=0b0100 at cycle 5. At cycle 7: rsp_valid=1, id=2, sum=0x1CE, carry=0.
- Round-robin fairness: all four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1,... one per cycle. Responses return in that id order with no gaps after 2-cycle fill.
- Pointer skip: after a grant to 1, only requesters 0 and 3 valid -> 3 is granted, then 0, then 3.
- Wrap arithmetic: a=0x3FF, b=0x001 -> sum=0x000, carry=1. a=0x200, b=0x200 -> sum=0x000, carry=1. a=0x1FF, b=0x1FF -> sum=0x3FE, carry=0.
- Backpressure: stream of 6 requests with rsp_ready low for cycles 10-13 ->
  - no req_ready during cycles 10-13;
  - rsp held stable;
  - stall_cnt=4;
  - all 6 responses delivered once, in order, with no loss or duplication.
- Reset mid-flight: rst high for 1 cycle with 2 results in the pipe -> rsp_valid=0 the next cycle and no stale response later. The first post-reset grant goes to the lowest valid index scanning from 0.
